// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg: op codes, error result and output state encoding
package alu_arbiter_pkg;
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam int MAX_W = 64;
  localparam logic [MAX_W-1:0] ERR_RESULT = '1;
  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_e;
endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: two requester channels plus the result channel
interface alu_arbiter_if #(parameter int DATA_W = 32);
  logic              req0_valid, req0_ready;
  logic [DATA_W-1:0] req0_a, req0_b;
  logic [3:0]        req0_op;
  logic              req1_valid, req1_ready;
  logic [DATA_W-1:0] req1_a, req1_b;
  logic [3:0]        req1_op;
  logic              out_valid, out_ready;
  logic [DATA_W-1:0] out_result;
  logic              out_zero, out_src, out_err;
  logic [15:0]       op_count;
  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op, out_ready,
    input  req0_ready, req1_ready, out_valid, out_result, out_zero, out_src, out_err, op_count
  );
  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op, out_ready,
    output req0_ready, req1_ready, out_valid, out_result, out_zero, out_src, out_err, op_count
  );
endinterface

// File: rtl/alu_arbiter_alu_core.sv
// alu_core: combinational ALU, unknown op codes yield all ones with err set
module alu_core
  import alu_arbiter_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [3:0]        op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] result_o,
  output logic              err_o
);
  // Decode the op code; the default path keeps the error pattern
  always_comb begin
    err_o    = 1'b0;
    result_o = ERR_RESULT[DATA_W-1:0];
    case (op_i)
      OP_ADD:  result_o = a_i + b_i;
      OP_SUB:  result_o = a_i - b_i;
      OP_AND:  result_o = a_i & b_i;
      OP_OR:   result_o = a_i | b_i;
      default: err_o = 1'b1;
    endcase
  end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one ALU between two requesters with a one-deep result register
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_arbiter_if.slave bus
);
  state_e            state_q, state_d;
  logic              ptr_q, ptr_d, src_q, src_d, zero_q, zero_d, err_q, err_d;
  logic [DATA_W-1:0] result_q, result_d, op_a, op_b, alu_result;
  logic [15:0]       count_q, count_d;
  logic [3:0]        op;
  logic              grant, can_accept, accept, alu_err;
  assign can_accept = rst_n & ((state_q == ST_EMPTY) | bus.out_ready);
  assign grant = (bus.req0_valid & bus.req1_valid) ? ptr_q : bus.req1_valid;
  assign bus.req0_ready = can_accept & ~grant & bus.req0_valid;
  assign bus.req1_ready = can_accept & grant & bus.req1_valid;
  assign accept = bus.req0_ready | bus.req1_ready;
  assign op_a = grant ? bus.req1_a : bus.req0_a;
  assign op_b = grant ? bus.req1_b : bus.req0_b;
  assign op = grant ? bus.req1_op : bus.req0_op;
  alu_core #(.DATA_W(DATA_W)) u_alu (
    .op_i    (op),
    .a_i     (op_a),
    .b_i     (op_b),
    .result_o(alu_result),
    .err_o   (alu_err)
  );
  // Next state: accept fills, an unrefilled drain empties, a stalled result holds
  always_comb begin
    state_d  = accept ? ST_FULL : ((state_q == ST_FULL) & ~bus.out_ready) ? ST_FULL : ST_EMPTY;
    ptr_d    = accept ? ~grant : ptr_q;
    result_d = accept ? alu_result : result_q;
    zero_d   = accept ? (alu_result == '0) : zero_q;
    src_d    = accept ? grant : src_q;
    err_d    = accept ? alu_err : err_q;
    count_d  = count_q + 16'((state_q == ST_FULL) & bus.out_ready);
  end
  // State, pointer, result register and delivery counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_EMPTY;
      ptr_q    <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      src_q    <= 1'b0;
      err_q    <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      src_q    <= src_d;
      err_q    <= err_d;
      count_q  <= count_d;
    end
  end
  assign bus.out_valid  = state_q == ST_FULL;
  assign bus.out_result = result_q;
  assign bus.out_zero   = zero_q;
  assign bus.out_src    = src_q;
  assign bus.out_err    = err_q;
  assign bus.op_count   = count_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed table, corner sequences and random traffic against a behavioural model
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;
  localparam int W = 32;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  alu_arbiter_if #(.DATA_W(W)) bus();
  alu_arbiter #(.DATA_W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  logic         m_full, m_src, m_err, m_zero;
  logic [W-1:0] m_res;
  logic [15:0]  m_cnt;
  int           m_ptr;

  typedef struct {
    logic v0; logic [3:0] o0; logic [W-1:0] a0, b0;
    logic v1; logic [3:0] o1; logic [W-1:0] a1, b1;
    logic [W-1:0] er; logic es, ee, ez;
  } vec_t;
  vec_t tbl[7];
  logic [3:0] ops[4];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [W:0] ref_alu(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      OP_ADD:  return {1'b0, W'(a + b)};
      OP_SUB:  return {1'b0, W'(a - b)};
      OP_AND:  return {1'b0, a & b};
      OP_OR:   return {1'b0, a | b};
      default: return {1'b1, {W{1'b1}}};
    endcase
  endfunction

  task automatic step(input logic v0, input logic [3:0] o0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                      input logic v1, input logic [3:0] o1, input logic [W-1:0] a1, input logic [W-1:0] b1,
                      input logic ordy);
    int win;
    bus.req0_valid = v0; bus.req0_op = o0; bus.req0_a = a0; bus.req0_b = b0;
    bus.req1_valid = v1; bus.req1_op = o1; bus.req1_a = a1; bus.req1_b = b1;
    bus.out_ready = ordy;
    win = -1;
    if (!m_full || ordy) begin
      if (v0 && v1) win = m_ptr;
      else if (v0) win = 0;
      else if (v1) win = 1;
    end
    #3;
    chk("req0_ready", bus.req0_ready, win == 0);
    chk("req1_ready", bus.req1_ready, win == 1);
    @(posedge clk);
    if (m_full && ordy) m_cnt++;
    if (win >= 0) begin
      {m_err, m_res} = (win == 0) ? ref_alu(o0, a0, b0) : ref_alu(o1, a1, b1);
      m_src = (win == 1);
      m_zero = (m_res == 0);
      m_full = 1'b1;
      m_ptr = (win == 0) ? 1 : 0;
    end else if (ordy) m_full = 1'b0;
    #1;
    chk("out_valid", bus.out_valid, m_full);
    if (m_full) begin
      chk("out_result", bus.out_result, m_res);
      chk("out_src", bus.out_src, m_src);
      chk("out_err", bus.out_err, m_err);
      chk("out_zero", bus.out_zero, m_zero);
    end
    chk("op_count", bus.op_count, m_cnt);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1; bus.out_ready = 1'b0;
    #3;
    chk("rst_ready0", bus.req0_ready, 0);
    chk("rst_ready1", bus.req1_ready, 0);
    @(posedge clk);
    #1;
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_result", bus.out_result, 0);
    chk("rst_flags", {bus.out_zero, bus.out_src, bus.out_err}, 0);
    chk("rst_count", bus.op_count, 0);
    rst_n = 1'b1;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    m_full = 1'b0; m_res = '0; m_src = 1'b0; m_err = 1'b0; m_zero = 1'b0; m_cnt = '0; m_ptr = 0;
  endtask

  function automatic logic [3:0] pick_op();
    int r = $urandom_range(0, 9);
    return (r < 8) ? ops[r % 4] : 4'($urandom);
  endfunction

  function automatic logic [W-1:0] pick_val();
    return ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : W'($urandom);
  endfunction

  initial begin
    ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR};
    tbl[0] = '{1, OP_ADD, 5, 7, 0, OP_ADD, 0, 0, 32'd12, 0, 0, 0};
    tbl[1] = '{0, OP_ADD, 0, 0, 1, OP_SUB, 0, 1, 32'hFFFF_FFFF, 1, 0, 0};
    tbl[2] = '{0, OP_ADD, 0, 0, 1, OP_SUB, 9, 9, 32'd0, 1, 0, 1};
    tbl[3] = '{1, 4'b1111, 1, 2, 0, OP_ADD, 0, 0, 32'hFFFF_FFFF, 0, 1, 0};
    tbl[4] = '{1, OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 0, OP_ADD, 0, 0, 32'hF000_F000, 0, 0, 0};
    tbl[5] = '{0, OP_ADD, 0, 0, 1, OP_OR, 32'h0000_00F0, 32'h0000_0F00, 32'h0000_0FF0, 1, 0, 0};
    tbl[6] = '{1, OP_ADD, 32'hFFFF_FFFF, 2, 0, OP_ADD, 0, 0, 32'd1, 0, 0, 0};
    bus.req0_valid = 1'b0; bus.req0_op = '0; bus.req0_a = '0; bus.req0_b = '0;
    bus.req1_valid = 1'b0; bus.req1_op = '0; bus.req1_a = '0; bus.req1_b = '0;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      step(tbl[i].v0, tbl[i].o0, tbl[i].a0, tbl[i].b0, tbl[i].v1, tbl[i].o1, tbl[i].a1, tbl[i].b1, 1'b1);
      chk("tbl_result", bus.out_result, tbl[i].er);
      chk("tbl_src", bus.out_src, tbl[i].es);
      chk("tbl_err", bus.out_err, tbl[i].ee);
      chk("tbl_zero", bus.out_zero, tbl[i].ez);
    end
    chk("tbl_count", bus.op_count, 6);
    do_reset();
    for (int k = 0; k < 4; k++) begin
      step(1, OP_ADD, W'(k), 100, 1, OP_ADD, W'(k), 200, 1'b1);
      chk("rr_src", bus.out_src, k % 2);
    end
    for (int k = 0; k < 3; k++) begin
      step(1, OP_SUB, 50, 1, 1, OP_OR, 3, 4, 1'b0);
      chk("stall_valid", bus.out_valid, 1);
      chk("stall_result", bus.out_result, 32'd203);
    end
    step(1, OP_SUB, 50, 1, 1, OP_OR, 3, 4, 1'b1);
    chk("refill_src", bus.out_src, 0);
    chk("refill_result", bus.out_result, 32'd49);
    step(1, OP_ADD, 1, 1, 0, OP_ADD, 0, 0, 1'b0);
    do_reset();
    step(1, OP_ADD, 2, 3, 1, OP_ADD, 4, 5, 1'b1);
    chk("ptr_after_reset", bus.out_src, 0);
    do_reset();
    for (int n = 0; n < 400; n++)
      step($urandom_range(0, 2) != 0, pick_op(), pick_val(), pick_val(),
           $urandom_range(0, 2) != 0, pick_op(), pick_val(), pick_val(),
           $urandom_range(0, 3) != 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
